// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES-128 decrypt round scheduler.
// Holds the FSM state encoding, round count, key count and block width.
package aes_dec_pkg;

   localparam int AES128_NR = 10;
   localparam int NKEYS     = AES128_NR + 1;
   localparam int BLK_W     = 128;

   typedef logic [BLK_W-1:0] blk_t;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      OUTPUT
   } sched_state_e;

endpackage

// File: rtl/aes_dec_round_sched_if.sv
// aes_dec_round_sched_if: 128-bit valid/ready block stream.
// master drives valid/data, slave drives ready.
interface aes_dec_round_sched_if;
   import aes_dec_pkg::*;

   logic valid;
   logic ready;
   blk_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: round-key register file with per-entry valid mask.
// One write port, one combinational read port, all_valid summary.
module aes_round_key_store
   import aes_dec_pkg::*;
#(
   parameter int NKEY = NKEYS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_idx,
   input  blk_t       wr_data,
   input  logic [3:0] rd_idx,
   output blk_t       rd_data,
   output logic       all_valid
);

   blk_t            mem [NKEY];
   logic [NKEY-1:0] vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else if (wr_en) begin
         vld[wr_idx] <= 1'b1;
      end
   end

   // Contents are don't-care after reset; only the mask is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data   = mem[rd_idx];
   assign all_valid = &vld;

endmodule

// File: rtl/aes_dec_round_sched.sv
// aes_dec_round_sched: AES-128 decrypt round scheduler.
// Drives the round datapath from round NR down to 0.
module aes_dec_round_sched
  import aes_dec_pkg::*;
#(
  parameter int NR          = AES128_NR,
  parameter int WDOG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_wr_en,
  input  logic [3:0] key_wr_idx,
  input  blk_t       key_wr_data,
  output logic       key_wr_err,
  input  logic       s_valid,
  output logic       s_ready,
  input  blk_t       s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output blk_t       m_data,
  output logic       busy,
  output logic       dp_start,
  output logic [3:0] dp_round,
  output blk_t       dp_key,
  output blk_t       dp_state,
  input  blk_t       dp_result,
  input  logic       dp_done,
  output logic       err_timeout
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  sched_state_e state_q, state_d;
  logic [3:0]   rnd_q, rnd_d, rd_idx;
  blk_t         key_q, key_d, st_q, st_d;
  blk_t         mdat_q, mdat_d;
  blk_t         rd_data, key_first;
  logic         all_valid, key_ok;
  logic         accept, wd_hit;

  assign key_ok = key_wr_en
               && state_q == IDLE
               && key_wr_idx <= NR_IDX;
  assign s_ready = state_q == IDLE
                && all_valid;
  assign accept = s_valid && s_ready;

  assign rd_idx =
    (state_q == WAIT && rnd_q != 4'd0)
    ? rnd_q - 4'd1 : NR_IDX;

  assign key_first =
    (key_ok && key_wr_idx == NR_IDX)
    ? key_wr_data : rd_data;

  aes_round_key_store #(
    .NKEY(NR + 1)
  ) u_keys (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (key_ok),
    .wr_idx    (key_wr_idx),
    .wr_data   (key_wr_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .all_valid (all_valid)
  );

`ifdef AES_DEC_SCHED_WDOG_EN
  localparam int WD_W =
    $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_hit =
    wd_q == WD_W'(WDOG_CYCLES - 1);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    key_d       = key_q;
    st_d        = st_q;
    mdat_d      = mdat_q;
    dp_start    = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          st_d    = s_data;
          rnd_d   = NR_IDX;
          key_d   = key_first;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        dp_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          st_d = dp_result;
          if (rnd_q == 4'd0) begin
            mdat_d  = dp_result;
            state_d = OUTPUT;
          end else begin
            rnd_d   = rnd_q - 4'd1;
            key_d   = rd_data;
            state_d = LAUNCH;
          end
        end else if (wd_hit) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      key_q      <= '0;
      st_q       <= '0;
      mdat_q     <= '0;
      key_wr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      st_q    <= st_d;
      mdat_q  <= mdat_d;
      if (key_wr_en && !key_ok) begin
        key_wr_err <= 1'b1;
      end
    end
  end

  assign busy     = state_q != IDLE;
  assign dp_round = rnd_q;
  assign dp_key   = key_q;
  assign dp_state = st_q;
  assign m_valid  = state_q == OUTPUT;
  assign m_data   = mdat_q;

endmodule
